// File: rtl/wb_write_sequencer_if.sv
// MEM/WB pipeline register fields consumed by the write-back sequencer,
// together with the GPR/CPR write ports and stall signals it produces.
interface wb_write_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int GPR_AW = 5,
    parameter int CPR_AW = 4,
    parameter int CNT_W  = 16
);
    logic              mem_to_reg;
    logic              reg_write_en;
    logic              b;
    logic              jal;
    logic [GPR_AW-1:0] write_register;
    logic [DATA_W-1:0] cache_data_out;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] PC;
    logic              reg_write_en_C;
    logic              complex;
    logic [CPR_AW-1:0] complex_write_register;
    logic [CPR_AW-1:0] complex_write_register2;
    logic              mem_to_reg_C;
    logic [DATA_W-1:0] mem_data1_out_C;
    logic [DATA_W-1:0] mem_data2_out_C;
    logic [DATA_W-1:0] alu_result2;

    logic              gpr_we;
    logic [GPR_AW-1:0] gpr_waddr;
    logic [DATA_W-1:0] gpr_wdata;
    logic              cpr_we;
    logic [CPR_AW-1:0] cpr_waddr;
    logic [DATA_W-1:0] cpr_wdata;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt;

    // Pipeline side: drives the MEM/WB fields and observes the write ports.
    modport master (
        output mem_to_reg, reg_write_en, b, jal, write_register, cache_data_out,
               alu_result, PC, reg_write_en_C, complex, complex_write_register,
               complex_write_register2, mem_to_reg_C, mem_data1_out_C,
               mem_data2_out_C, alu_result2,
        input  gpr_we, gpr_waddr, gpr_wdata, cpr_we, cpr_waddr, cpr_wdata,
               stall_o, stall_cnt
    );

    // Sequencer side.
    modport slave (
        input  mem_to_reg, reg_write_en, b, jal, write_register, cache_data_out,
               alu_result, PC, reg_write_en_C, complex, complex_write_register,
               complex_write_register2, mem_to_reg_C, mem_data1_out_C,
               mem_data2_out_C, alu_result2,
        output gpr_we, gpr_waddr, gpr_wdata, cpr_we, cpr_waddr, cpr_wdata,
               stall_o, stall_cnt
    );
endinterface

// File: rtl/wb_write_sequencer.sv
// Write-back stage: drives the GPR write port and serializes two-destination
// complex results over the single CPR write port, stalling upstream once.
module wb_write_sequencer #(
    parameter int DATA_W = 32,
    parameter int GPR_AW = 5,
    parameter int CPR_AW = 4,
    parameter int CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst_b,
    wb_write_sequencer_if.slave  bus
);
    localparam logic [GPR_AW-1:0] LINK_REG = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t            state;
    state_t            state_next;
    logic              cpr_req;
    logic              need2;
    logic [DATA_W-1:0] word1;
    logic [DATA_W-1:0] word2;
    logic              gpr_we_next;
    logic [GPR_AW-1:0] gpr_addr_sel;
    logic [DATA_W-1:0] gpr_data_sel;
    logic [CPR_AW-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;

    // Decode the pipeline fields into the candidate GPR and CPR writes.
    always_comb begin
        cpr_req      = bus.complex & bus.reg_write_en_C;
        need2        = cpr_req & (bus.complex_write_register2 != bus.complex_write_register);
        word1        = bus.mem_to_reg_C ? bus.mem_data1_out_C : bus.alu_result;
        word2        = bus.mem_to_reg_C ? bus.mem_data2_out_C : bus.alu_result2;
        gpr_addr_sel = bus.jal ? LINK_REG : bus.write_register;
        gpr_data_sel = bus.jal ? (bus.PC + DATA_W'(4))
                               : (bus.mem_to_reg ? bus.cache_data_out : bus.alu_result);
        gpr_we_next  = bus.reg_write_en & ~bus.b & (gpr_addr_sel != '0);
    end

    // Next state and upstream stall; stall is held low while reset is asserted.
    always_comb begin
        state_next  = state;
        bus.stall_o = 1'b0;
        case (state)
            IDLE: begin
                if (need2) begin
                    bus.stall_o = rst_b;
                    state_next  = SECOND;
                end
            end
            SECOND: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_next;
    end

    // Registered GPR and CPR write ports; SECOND replays the held second word.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bus.gpr_we    <= 1'b0;
            bus.gpr_waddr <= '0;
            bus.gpr_wdata <= '0;
            bus.cpr_we    <= 1'b0;
            bus.cpr_waddr <= '0;
            bus.cpr_wdata <= '0;
        end else if (state == SECOND) begin
            bus.gpr_we    <= 1'b0;
            bus.cpr_we    <= 1'b1;
            bus.cpr_waddr <= hold_addr;
            bus.cpr_wdata <= hold_data;
        end else begin
            bus.gpr_we    <= gpr_we_next;
            bus.gpr_waddr <= gpr_addr_sel;
            bus.gpr_wdata <= gpr_data_sel;
            if (cpr_req) begin
                bus.cpr_we    <= 1'b1;
                bus.cpr_waddr <= bus.complex_write_register;
                bus.cpr_wdata <= need2 ? word1 : word2;
            end else begin
                bus.cpr_we <= 1'b0;
            end
        end
    end

    // Capture the second destination and word when a dual write begins.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if ((state == IDLE) && need2) begin
            hold_addr <= bus.complex_write_register2;
            hold_data <= word2;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)                                  bus.stall_cnt <= '0;
        else if (bus.stall_o && bus.stall_cnt != CNT_MAX) bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_wb_write_sequencer.sv
// Testbench for wb_write_sequencer: directed scenarios plus randomized traffic
// checked against a pending-write reference model.
module tb_wb_write_sequencer;
    logic clk;
    logic rst_b;

    wb_write_sequencer_if #(.DATA_W(32), .GPR_AW(5), .CPR_AW(4), .CNT_W(16)) bus ();
    wb_write_sequencer_if #(.DATA_W(32), .GPR_AW(5), .CPR_AW(4), .CNT_W(2))  bus2 ();

    wb_write_sequencer #(.DATA_W(32), .GPR_AW(5), .CPR_AW(4), .CNT_W(16)) dut (
        .clk(clk), .rst_b(rst_b), .bus(bus.slave));
    wb_write_sequencer #(.DATA_W(32), .GPR_AW(5), .CPR_AW(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst_b(rst_b), .bus(bus2.slave));

    assign bus2.mem_to_reg              = bus.mem_to_reg;
    assign bus2.reg_write_en            = bus.reg_write_en;
    assign bus2.b                       = bus.b;
    assign bus2.jal                     = bus.jal;
    assign bus2.write_register          = bus.write_register;
    assign bus2.cache_data_out          = bus.cache_data_out;
    assign bus2.alu_result              = bus.alu_result;
    assign bus2.PC                      = bus.PC;
    assign bus2.reg_write_en_C          = bus.reg_write_en_C;
    assign bus2.complex                 = bus.complex;
    assign bus2.complex_write_register  = bus.complex_write_register;
    assign bus2.complex_write_register2 = bus.complex_write_register2;
    assign bus2.mem_to_reg_C            = bus.mem_to_reg_C;
    assign bus2.mem_data1_out_C         = bus.mem_data1_out_C;
    assign bus2.mem_data2_out_C         = bus.mem_data2_out_C;
    assign bus2.alu_result2             = bus.alu_result2;

    int vectors;
    int miscompares;

    // Reference model: expected registered outputs and any pending second CPR write.
    bit          m_pending;
    logic [3:0]  m_paddr;
    logic [31:0] m_pdata;
    int          m_stalls;
    logic        e_gpr_we;
    logic [4:0]  e_gpr_waddr;
    logic [31:0] e_gpr_wdata;
    logic        e_cpr_we;
    logic [3:0]  e_cpr_waddr;
    logic [31:0] e_cpr_wdata;
    logic        exp_stall;
    logic        obs_stall;
    logic        obs_stall2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int small_cnt(int n);
        return (n > 3) ? 3 : n;
    endfunction

    task automatic model_reset();
        m_pending   = 0;
        m_paddr     = '0;
        m_pdata     = '0;
        m_stalls    = 0;
        e_gpr_we    = 0;
        e_gpr_waddr = '0;
        e_gpr_wdata = '0;
        e_cpr_we    = 0;
        e_cpr_waddr = '0;
        e_cpr_wdata = '0;
    endtask

    // Apply the write-back rules to the inputs present at a clock edge.
    task automatic model_step();
        logic [4:0]  ga;
        logic [31:0] w1;
        logic [31:0] w2;
        if (m_pending) begin
            e_gpr_we    = 0;
            e_cpr_we    = 1;
            e_cpr_waddr = m_paddr;
            e_cpr_wdata = m_pdata;
            m_pending   = 0;
        end else begin
            ga          = bus.jal ? 5'd31 : bus.write_register;
            e_gpr_we    = bus.reg_write_en && !bus.b && (ga != 0);
            e_gpr_waddr = ga;
            e_gpr_wdata = bus.jal ? bus.PC + 32'd4 : (bus.mem_to_reg ? bus.cache_data_out : bus.alu_result);
            w1 = bus.mem_to_reg_C ? bus.mem_data1_out_C : bus.alu_result;
            w2 = bus.mem_to_reg_C ? bus.mem_data2_out_C : bus.alu_result2;
            if (bus.complex && bus.reg_write_en_C) begin
                e_cpr_we    = 1;
                e_cpr_waddr = bus.complex_write_register;
                if (bus.complex_write_register2 == bus.complex_write_register) begin
                    e_cpr_wdata = w2;
                end else begin
                    e_cpr_wdata = w1;
                    m_pending   = 1;
                    m_paddr     = bus.complex_write_register2;
                    m_pdata     = w2;
                    m_stalls++;
                end
            end else begin
                e_cpr_we = 0;
            end
        end
    endtask

    task automatic clear_inputs();
        bus.mem_to_reg = 0; bus.reg_write_en = 0; bus.b = 0; bus.jal = 0;
        bus.write_register = '0; bus.cache_data_out = '0; bus.alu_result = '0; bus.PC = '0;
        bus.reg_write_en_C = 0; bus.complex = 0; bus.complex_write_register = '0;
        bus.complex_write_register2 = '0; bus.mem_to_reg_C = 0; bus.mem_data1_out_C = '0;
        bus.mem_data2_out_C = '0; bus.alu_result2 = '0;
    endtask

    // One clock: sample stall before the edge, advance the model, return at the negedge.
    task automatic cycle();
        #2;
        exp_stall  = !m_pending && bus.complex && bus.reg_write_en_C &&
                     (bus.complex_write_register != bus.complex_write_register2);
        obs_stall  = bus.stall_o;
        obs_stall2 = bus2.stall_o;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_b = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_b = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_b = 1;
        @(negedge clk);
        rst_b = 0;
        model_reset();
        #1;
        vectors++;
        if ({bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata,
             bus.stall_o, bus.stall_cnt, bus2.stall_cnt} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got gpr %0b/%0d/%h cpr %0b/%0d/%h stall %0b cnt %0d/%0d expected all zero",
                     bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata,
                     bus.stall_o, bus.stall_cnt, bus2.stall_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        rst_b = 1;
        cycle();
        vectors++;
        if (bus.gpr_we !== 1'b0 || bus.cpr_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle_we: got gpr_we %0b cpr_we %0b expected 0 0", bus.gpr_we, bus.cpr_we);
        end
    endtask

    task automatic test_alu_gpr();
        do_reset();
        bus.reg_write_en = 1; bus.write_register = 5'd5;
        bus.alu_result = 32'h1234; bus.cache_data_out = 32'hDEAD_BEEF;
        cycle();
        vectors++;
        if ({bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
            miscompares++;
            $display("[TB] FAIL alu_gpr: got %0b/%0d/%h expected 1/5/00001234", bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata);
        end
        bus.mem_to_reg = 1; bus.write_register = 5'd9;
        cycle();
        vectors++;
        if ({bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata} !== {1'b1, 5'd9, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("[TB] FAIL load_gpr: got %0b/%0d/%h expected 1/9/deadbeef", bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata);
        end
    endtask

    task automatic test_jal();
        do_reset();
        bus.jal = 1; bus.reg_write_en = 1; bus.PC = 32'h400; bus.write_register = 5'd7;
        cycle();
        vectors++;
        if ({bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata} !== {1'b1, 5'd31, 32'h404}) begin
            miscompares++;
            $display("[TB] FAIL jal_link: got %0b/%0d/%h expected 1/31/00000404", bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata);
        end
        bus.PC = 32'hFFFF_FFFC;
        cycle();
        vectors++;
        if (bus.gpr_wdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL jal_wrap: got %h expected 00000000", bus.gpr_wdata);
        end
        bus.jal = 0; bus.b = 1;
        cycle();
        vectors++;
        if (bus.gpr_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL branch_suppress: got gpr_we %0b expected 0", bus.gpr_we);
        end
        bus.b = 0; bus.write_register = 5'd0;
        cycle();
        vectors++;
        if (bus.gpr_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL addr0_suppress: got gpr_we %0b expected 0", bus.gpr_we);
        end
    endtask

    task automatic test_dual_cpr();
        do_reset();
        bus.complex = 1; bus.reg_write_en_C = 1; bus.mem_to_reg_C = 1;
        bus.complex_write_register = 4'd3; bus.complex_write_register2 = 4'd4;
        bus.mem_data1_out_C = 32'hA; bus.mem_data2_out_C = 32'hB; bus.alu_result = 32'h55;
        cycle();
        vectors++;
        if ({obs_stall, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata} !== {1'b1, 1'b1, 4'd3, 32'hA}) begin
            miscompares++;
            $display("[TB] FAIL dual_first: got stall %0b cpr %0b/%0d/%h expected 1 1/3/0000000a",
                     obs_stall, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata);
        end
        bus.complex_write_register = 4'd9; bus.complex_write_register2 = 4'd10;
        bus.mem_data1_out_C = 32'h99; bus.reg_write_en = 1; bus.write_register = 5'd12;
        cycle();
        vectors++;
        if ({obs_stall, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata, bus.gpr_we} !== {1'b0, 1'b1, 4'd4, 32'hB, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL dual_second: got stall %0b cpr %0b/%0d/%h gpr_we %0b expected 0 1/4/0000000b 0",
                     obs_stall, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata, bus.gpr_we);
        end
        vectors++;
        if (bus.stall_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL dual_stall_cnt: got %0d expected 1", bus.stall_cnt);
        end
        clear_inputs();
        cycle();
        vectors++;
        if ({bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata} !== {1'b0, 4'd4, 32'hB}) begin
            miscompares++;
            $display("[TB] FAIL cpr_hold: got %0b/%0d/%h expected 0/4/0000000b", bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata);
        end
    endtask

    task automatic test_same_dest();
        do_reset();
        bus.complex = 1; bus.reg_write_en_C = 1; bus.mem_to_reg_C = 0;
        bus.complex_write_register = 4'd6; bus.complex_write_register2 = 4'd6;
        bus.alu_result = 32'h11; bus.alu_result2 = 32'h77;
        cycle();
        vectors++;
        if ({obs_stall, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata} !== {1'b0, 1'b1, 4'd6, 32'h77}) begin
            miscompares++;
            $display("[TB] FAIL same_dest: got stall %0b cpr %0b/%0d/%h expected 0 1/6/00000077",
                     obs_stall, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata);
        end
        clear_inputs();
        cycle();
        vectors++;
        if (bus.cpr_we !== 1'b0 || bus.stall_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL same_dest_after: got cpr_we %0b stall_cnt %0d expected 0 0", bus.cpr_we, bus.stall_cnt);
        end
    endtask

    task automatic test_reset_in_second();
        do_reset();
        bus.complex = 1; bus.reg_write_en_C = 1; bus.mem_to_reg_C = 1;
        bus.complex_write_register = 4'd3; bus.complex_write_register2 = 4'd4;
        bus.mem_data1_out_C = 32'hA; bus.mem_data2_out_C = 32'hB; bus.reg_write_en = 1; bus.write_register = 5'd2;
        cycle();
        rst_b = 0;
        model_reset();
        #1;
        vectors++;
        if ({bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata,
             bus.stall_o, bus.stall_cnt} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_second: got gpr %0b cpr %0b/%0d/%h stall %0b cnt %0d expected all zero",
                     bus.gpr_we, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata, bus.stall_o, bus.stall_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst_b = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (bus.cpr_we !== 1'b0 || bus.cpr_waddr === 4'd4) begin
                miscompares++;
                $display("[TB] FAIL no_pending_write[%0d]: got cpr_we %0b addr %0d expected no write to 4",
                         i, bus.cpr_we, bus.cpr_waddr);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.complex = 1; bus.reg_write_en_C = 1; bus.mem_to_reg_C = 0;
        for (int k = 0; k < 4; k++) begin
            bus.complex_write_register  = 4'(2 * k);
            bus.complex_write_register2 = 4'(2 * k + 1);
            bus.alu_result  = 32'(100 + k);
            bus.alu_result2 = 32'(200 + k);
            cycle();
            cycle();
            vectors++;
            if ({bus.cpr_waddr, bus.cpr_wdata} !== {4'(2 * k + 1), 32'(200 + k)}) begin
                miscompares++;
                $display("[TB] FAIL b2b_second[%0d]: got %0d/%0d expected %0d/%0d",
                         k, bus.cpr_waddr, bus.cpr_wdata, 2 * k + 1, 200 + k);
            end
        end
        vectors++;
        if (bus2.stall_cnt !== 2'd3 || bus.stall_cnt !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL saturation: got small %0d wide %0d expected 3 4", bus2.stall_cnt, bus.stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.mem_to_reg     = 1'($urandom);
            bus.reg_write_en   = 1'($urandom);
            bus.b              = ($urandom_range(0, 3) == 0);
            bus.jal            = ($urandom_range(0, 3) == 0);
            bus.write_register = 5'($urandom_range(0, 7));
            bus.cache_data_out = $urandom;
            bus.alu_result     = $urandom;
            bus.PC             = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.reg_write_en_C = ($urandom_range(0, 3) != 0);
            bus.complex        = 1'($urandom);
            bus.complex_write_register  = 4'($urandom_range(0, 3));
            bus.complex_write_register2 = 4'($urandom_range(0, 3));
            bus.mem_to_reg_C    = 1'($urandom);
            bus.mem_data1_out_C = $urandom;
            bus.mem_data2_out_C = $urandom;
            bus.alu_result2     = $urandom;
            cycle();
            vectors++;
            if (obs_stall !== exp_stall || obs_stall2 !== exp_stall) begin
                miscompares++;
                $display("[TB] FAIL rand_stall[%0d]: got %0b/%0b expected %0b", n, obs_stall, obs_stall2, exp_stall);
            end
            vectors++;
            if (bus.gpr_we !== e_gpr_we) begin
                miscompares++;
                $display("[TB] FAIL rand_gpr_we[%0d]: got %0b expected %0b", n, bus.gpr_we, e_gpr_we);
            end
            if (e_gpr_we) begin
                vectors++;
                if (bus.gpr_waddr !== e_gpr_waddr || bus.gpr_wdata !== e_gpr_wdata) begin
                    miscompares++;
                    $display("[TB] FAIL rand_gpr_write[%0d]: got %0d/%h expected %0d/%h",
                             n, bus.gpr_waddr, bus.gpr_wdata, e_gpr_waddr, e_gpr_wdata);
                end
            end
            vectors++;
            if ({bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata} !== {e_cpr_we, e_cpr_waddr, e_cpr_wdata}) begin
                miscompares++;
                $display("[TB] FAIL rand_cpr[%0d]: got %0b/%0d/%h expected %0b/%0d/%h",
                         n, bus.cpr_we, bus.cpr_waddr, bus.cpr_wdata, e_cpr_we, e_cpr_waddr, e_cpr_wdata);
            end
            vectors++;
            if (bus.stall_cnt !== 16'(m_stalls) || bus2.stall_cnt !== 2'(small_cnt(m_stalls))) begin
                miscompares++;
                $display("[TB] FAIL rand_stall_cnt[%0d]: got %0d/%0d expected %0d/%0d",
                         n, bus.stall_cnt, bus2.stall_cnt, m_stalls, small_cnt(m_stalls));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_b       = 1;
        clear_inputs();
        model_reset();
        test_reset();
        test_alu_gpr();
        test_jal();
        test_dual_cpr();
        test_same_dest();
        test_reset_in_second();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
